ei_axi4_wr_arbiter: RTL and testbench

Write-path arbiter for the AXI4 VIP environment. It shares one AXI4 slave write port (AW, W and B channels) between NUM_MST requesting masters. A master is granted for one complete transaction: its address phase, all data beats through WLAST, and its write response. Grants rotate round-robin. The block sits between the VIP master-side interfaces and the single slave/memory model.

---
 rtl/ei_axi4_arb_pkg.sv | 18 +
 rtl/ei_axi4_rr_arbiter.sv | 30 +++
 rtl/ei_axi4_wr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ei_axi4_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ei_axi4_arb_pkg.sv
// Shared types and constants for the AXI4 write-path arbiter.
package ei_axi4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } ei_axi4_arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int unsigned AWLEN_W = 8;

endpackage

// File: rtl/ei_axi4_rr_arbiter.sv
// Combinational round-robin picker: search begins one past last_owner.
module ei_axi4_rr_arbiter #(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_MST-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            cand = IDX_W'((32'(last_owner) + k) % NUM_MST);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ei_axi4_wr_arbiter.sv
// AXI4 write-path arbiter: one master owns AW/W/B for a whole transaction.
// Optional burst-length checker enabled by defining EI_AXI4_ARB_LEN_CHK_EN.
module ei_axi4_wr_arbiter
    import ei_axi4_arb_pkg::*;
#(
    parameter int unsigned NUM_MST    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_MST-1:0]                  m_awvalid,
    output logic [NUM_MST-1:0]                  m_awready,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]       m_awaddr,
    input  logic [NUM_MST*ID_WIDTH-1:0]         m_awid,
    input  logic [NUM_MST*8-1:0]                m_awlen,
    input  logic [NUM_MST*3-1:0]                m_awsize,
    input  logic [NUM_MST*2-1:0]                m_awburst,
    input  logic [NUM_MST-1:0]                  m_wvalid,
    output logic [NUM_MST-1:0]                  m_wready,
    input  logic [NUM_MST*DATA_WIDTH-1:0]       m_wdata,
    input  logic [NUM_MST*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [NUM_MST-1:0]                  m_wlast,
    output logic [NUM_MST-1:0]                  m_bvalid,
    input  logic [NUM_MST-1:0]                  m_bready,
    output logic [ID_WIDTH-1:0]                 m_bid,
    output logic [1:0]                          m_bresp,
    output logic                                s_awvalid,
    input  logic                                s_awready,
    output logic [ADDR_WIDTH-1:0]               s_awaddr,
    output logic [ID_WIDTH-1:0]                 s_awid,
    output logic [7:0]                          s_awlen,
    output logic [2:0]                          s_awsize,
    output logic [1:0]                          s_awburst,
    output logic                                s_wvalid,
    input  logic                                s_wready,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    output logic                                s_wlast,
    input  logic                                s_bvalid,
    input  logic [ID_WIDTH-1:0]                 s_bid,
    input  logic [1:0]                          s_bresp,
    output logic                                s_bready,
    output logic [NUM_MST-1:0]                  grant,
    output logic                                busy,
    output logic                                len_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_MST);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    ei_axi4_arb_state_e state, state_n;
    logic [IDX_W-1:0]   owner, last_owner, win_idx;
    logic [NUM_MST-1:0] win_oh, grant_q;
    logic               aw_hs, w_hs, b_hs;

    logic [ADDR_WIDTH-1:0] awaddr_a  [NUM_MST];
    logic [ID_WIDTH-1:0]   awid_a    [NUM_MST];
    logic [AWLEN_W-1:0]    awlen_a   [NUM_MST];
    logic [2:0]            awsize_a  [NUM_MST];
    logic [1:0]            awburst_a [NUM_MST];
    logic [DATA_WIDTH-1:0] wdata_a   [NUM_MST];
    logic [STRB_W-1:0]     wstrb_a   [NUM_MST];

    for (genvar g = 0; g < NUM_MST; g++) begin : g_slice
        assign awaddr_a[g]  = m_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign awid_a[g]    = m_awid[g*ID_WIDTH +: ID_WIDTH];
        assign awlen_a[g]   = m_awlen[g*AWLEN_W +: AWLEN_W];
        assign awsize_a[g]  = m_awsize[g*3 +: 3];
        assign awburst_a[g] = m_awburst[g*2 +: 2];
        assign wdata_a[g]   = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_a[g]   = m_wstrb[g*STRB_W +: STRB_W];
    end

    ei_axi4_rr_arbiter #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (m_awvalid),
        .last_owner (last_owner),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Payloads follow the owner unconditionally; only valid/ready are gated by state.
    assign s_awaddr  = awaddr_a[owner];
    assign s_awid    = awid_a[owner];
    assign s_awlen   = awlen_a[owner];
    assign s_awsize  = awsize_a[owner];
    assign s_awburst = awburst_a[owner];
    assign s_wdata   = wdata_a[owner];
    assign s_wstrb   = wstrb_a[owner];
    assign s_wlast   = m_wlast[owner];
    assign m_bid     = s_bid;
    assign m_bresp   = s_bresp;
    assign grant     = grant_q;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n   = state;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        case (state)
            IDLE: begin
                if (|m_awvalid) state_n = ADDR;
            end
            ADDR: begin
                s_awvalid        = m_awvalid[owner];
                m_awready[owner] = s_awready;
                aw_hs            = m_awvalid[owner] & s_awready;
                if (aw_hs) state_n = DATA;
            end
            DATA: begin
                s_wvalid        = m_wvalid[owner];
                m_wready[owner] = s_wready;
                w_hs            = m_wvalid[owner] & s_wready;
                if (w_hs && m_wlast[owner]) state_n = RESP;
            end
            RESP: begin
                m_bvalid[owner] = s_bvalid;
                s_bready        = m_bready[owner];
                b_hs            = s_bvalid & m_bready[owner];
                if (b_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_MST - 1);
            grant_q    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |m_awvalid) begin
                owner   <= win_idx;
                grant_q <= win_oh;
            end
            if (state == RESP && b_hs) begin
                last_owner <= owner;
                grant_q    <= '0;
            end
        end
    end

`ifdef EI_AXI4_ARB_LEN_CHK_EN
    logic [AWLEN_W-1:0] beat_cnt;
    logic               len_err_q;

    // A beat is wrong when wlast disagrees with "counter has reached zero".
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (aw_hs) begin
            beat_cnt <= awlen_a[owner];
        end else if (w_hs) begin
            beat_cnt <= beat_cnt - AWLEN_W'(1);
            if (m_wlast[owner] != (beat_cnt == '0)) len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_ei_axi4_wr_arbiter.sv
// Self-checking bench for ei_axi4_wr_arbiter with a transaction-level reference model.
module tb_ei_axi4_wr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
`ifdef EI_AXI4_ARB_LEN_CHK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              areset;
    logic [NM-1:0]     m_awvalid, m_awready;
    logic [NM*AW-1:0]  m_awaddr;
    logic [NM*IW-1:0]  m_awid;
    logic [NM*8-1:0]   m_awlen;
    logic [NM*3-1:0]   m_awsize;
    logic [NM*2-1:0]   m_awburst;
    logic [NM-1:0]     m_wvalid, m_wready, m_wlast;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*SW-1:0]  m_wstrb;
    logic [NM-1:0]     m_bvalid, m_bready;
    logic [IW-1:0]     m_bid;
    logic [1:0]        m_bresp;
    logic              s_awvalid, s_awready;
    logic [AW-1:0]     s_awaddr;
    logic [IW-1:0]     s_awid;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_wvalid, s_wready, s_wlast;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_bvalid, s_bready;
    logic [IW-1:0]     s_bid;
    logic [1:0]        s_bresp;
    logic [NM-1:0]     grant;
    logic              busy, len_err;

    int          total = 0;
    int          bad = 0;
    int          busy_cycles = 0;
    int unsigned exp_last = NM - 1;
    logic        tgl = 1'b0;

    ei_axi4_wr_arbiter #(
        .NUM_MST    (NM),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic tickb;
        @(posedge aclk);
        #1;
        if (busy) busy_cycles++;
    endtask

    // Rotation order after an owner finishes: owner+1, owner+2, ... wrapping.
    function automatic int rr_pick(input logic [NM-1:0] req, input int unsigned last);
        int idx;
        for (int k = 1; k <= NM; k++) begin
            idx = int'((last + k) % NM);
            if (((req >> idx) & 1) != 0) return idx;
        end
        return 0;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"},    64'(grant),     64'(0));
        chk({tag, "_busy"},     64'(busy),      64'(0));
        chk({tag, "_s_awvalid"},64'(s_awvalid), 64'(0));
        chk({tag, "_s_wvalid"}, 64'(s_wvalid),  64'(0));
        chk({tag, "_s_bready"}, 64'(s_bready),  64'(0));
        chk({tag, "_m_awready"},64'(m_awready), 64'(0));
        chk({tag, "_m_wready"}, 64'(m_wready),  64'(0));
        chk({tag, "_m_bvalid"}, 64'(m_bvalid),  64'(0));
    endtask

    // bp: 0 = slave always ready, 1 = s_wready toggles each cycle, 2 = random.
    // early_last >= 0 places wlast on that beat instead of on beat awlen.
    task automatic run_txn(input logic [NM-1:0] req, input int bp, input int bstall,
                           input int early_last, input int len_in);
        int            w, len, nb, guard;
        logic          hs, lst;
        logic [NM-1:0] oh;
        logic [AW-1:0] addr;
        logic [IW-1:0] id, bid;
        logic [1:0]    bresp;
        logic [DW-1:0] d;
        logic [SW-1:0] st;
        logic [DW+SW:0] exp_q[$];
        logic [DW+SW:0] got_q[$];

        w    = rr_pick(req, exp_last);
        oh   = NM'(1) << w;
        len  = (len_in >= 0) ? len_in : int'($urandom_range(0, 7));
        addr = $urandom;
        id   = IW'($urandom_range(0, 15));
        m_awaddr[w*AW +: AW]  = addr;
        m_awid[w*IW +: IW]    = id;
        m_awlen[w*8 +: 8]     = 8'(len);
        m_awsize[w*3 +: 3]    = 3'd2;
        m_awburst[w*2 +: 2]   = 2'b01;
        m_awvalid   = req;
        s_awready   = (bp == 0);
        busy_cycles = 0;

        tickb;
        chk("aw_grant",   64'(grant),     64'(oh));
        chk("aw_busy",    64'(busy),      64'(1));
        chk("s_awvalid",  64'(s_awvalid), 64'(1));
        chk("s_awaddr",   64'(s_awaddr),  64'(addr));
        chk("s_awid",     64'(s_awid),    64'(id));
        chk("s_awlen",    64'(s_awlen),   64'(len));
        if (bp != 0) begin
            chk("aw_stall_ready", 64'(m_awready), 64'(0));
            tickb;
            chk("aw_stall_grant", 64'(grant), 64'(oh));
            s_awready = 1'b1;
            #1;
        end
        chk("m_awready", 64'(m_awready), 64'(oh));
        tickb;
        m_awvalid = req & ~oh;
        s_awready = 1'b0;

        nb = (early_last >= 0) ? early_last + 1 : len + 1;
        for (int b = 0; b < nb; b++) begin
            d   = $urandom;
            st  = SW'($urandom);
            lst = (b == nb - 1);
            m_wvalid             = oh;
            m_wdata[w*DW +: DW]  = d;
            m_wstrb[w*SW +: SW]  = st;
            m_wlast              = lst ? oh : '0;
            exp_q.push_back({lst, st, d});
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                if (bp == 0) s_wready = 1'b1;
                else if (bp == 1) begin
                    tgl      = ~tgl;
                    s_wready = tgl;
                end else s_wready = 1'($urandom_range(0, 1));
                #1;
                chk("s_wvalid", 64'(s_wvalid), 64'(1));
                chk("m_wready", 64'(m_wready), s_wready ? 64'(oh) : 64'(0));
                if (s_wready) begin
                    got_q.push_back({s_wlast, s_wstrb, s_wdata});
                    hs = 1'b1;
                end
                guard++;
                tickb;
            end
            chk("w_handshake", 64'(hs), 64'(1));
        end
        m_wvalid = '0;
        m_wlast  = '0;
        s_wready = 1'b0;
        chk("beat_count", 64'(got_q.size()), 64'(nb));
        for (int b = 0; b < nb && b < got_q.size(); b++)
            chk("beat", 64'(got_q[b]), 64'(exp_q[b]));

        bid      = IW'($urandom_range(0, 15));
        bresp    = 2'($urandom_range(0, 3));
        s_bvalid = 1'b1;
        s_bid    = bid;
        s_bresp  = bresp;
        m_bready = '0;
        for (int i = 0; i < bstall; i++) begin
            #1;
            chk("bstall_bvalid", 64'(m_bvalid), 64'(oh));
            chk("bstall_bready", 64'(s_bready), 64'(0));
            chk("bstall_grant",  64'(grant),    64'(oh));
            tickb;
        end
        m_bready = oh;
        #1;
        chk("s_bready", 64'(s_bready), 64'(1));
        chk("m_bvalid", 64'(m_bvalid), 64'(oh));
        chk("m_bid",    64'(m_bid),    64'(bid));
        chk("m_bresp",  64'(m_bresp),  64'(bresp));
        tickb;
        s_bvalid = 1'b0;
        m_bready = '0;
        chk("end_busy",  64'(busy),  64'(0));
        chk("end_grant", 64'(grant), 64'(0));
        // Busy covers ADDR, every DATA cycle and RESP; the IDLE cycle is outside it.
        if (bp == 0 && bstall == 0 && early_last < 0)
            chk("busy_cycles", 64'(busy_cycles), 64'(len + 3));
        exp_last = w;
    endtask

    initial begin
        int            w;
        logic [NM-1:0] oh;

        areset    = 1'b1;
        m_awvalid = '1;
        m_awaddr  = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wvalid  = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
        m_bready  = '0;
        s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid  = 1'b0; s_bid = '0; s_bresp = '0;
        tick;
        tick;
        check_quiet("reset");
        chk("reset_len_err", 64'(len_err), 64'(0));
        areset    = 1'b0;
        m_awvalid = '0;
        tick;

        repeat (6) run_txn(2'b11, 2, 0, -1, -1);
        run_txn(2'b01, 0, 0, -1, 3);
        run_txn(2'b01, 1, 0, -1, 7);
        run_txn(2'b11, 0, 5, -1, 2);
        chk("pre_len_err", 64'(len_err), 64'(0));

        run_txn(2'b01, 0, 0, 1, 3);
        chk("len_err_set", 64'(len_err), 64'(LEN_CHK));
        run_txn(2'b01, 2, 0, -1, -1);
        chk("len_err_sticky", 64'(len_err), 64'(LEN_CHK));

        w  = rr_pick(2'b11, exp_last);
        oh = NM'(1) << w;
        m_awlen[w*8 +: 8] = 8'd3;
        m_awvalid = 2'b11;
        s_awready = 1'b1;
        tick;
        tick;
        m_awvalid = 2'b11 & ~oh;
        s_awready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_wvalid            = oh;
            m_wdata[w*DW +: DW] = $urandom;
            m_wlast             = '0;
            s_wready            = 1'b1;
            tick;
        end
        chk("mid_busy",  64'(busy),  64'(1));
        chk("mid_grant", 64'(grant), 64'(oh));
        areset = 1'b1;
        tick;
        check_quiet("mid_reset");
        chk("mid_reset_len_err", 64'(len_err), 64'(0));
        areset    = 1'b0;
        m_wvalid  = '0;
        m_awvalid = '0;
        s_wready  = 1'b0;
        exp_last  = NM - 1;
        tick;
        run_txn(2'b11, 0, 0, -1, 1);
        chk("post_reset_owner", 64'(exp_last), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
